// File: rtl/spi_pwm_pkg.sv
// rtl/spi_pwm_pkg.sv - shared types and register map for the SPI PWM command controller
//
// Purpose: FSM state encoding, register addresses and address-decode helper
//          shared by spi_pwm_cmd_ctrl and its testbench.
// Ports:   none (package)

package spi_pwm_pkg;

  typedef enum logic [1:0] {IDLE, CMD, HI, LO} state_t;

  localparam logic [6:0] ADDR_CTRL        = 7'h00;
  localparam logic [6:0] ADDR_PERIOD      = 7'h01;
  localparam logic [6:0] ADDR_DUTY0       = 7'h10;
  localparam int         CTRL_CLR_ERR_BIT = 15;

  // DUTY[i] lives at ADDR_DUTY0 + i; only the first num_ch slots of that
  // 16-word window are backed by a channel.
  function automatic logic addr_is_duty(input logic [6:0] addr, input int num_ch);
    return (addr[6:4] == ADDR_DUTY0[6:4]) && (int'(addr[3:0]) < num_ch);
  endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// rtl/pwm_shadow_reg.sv - double-buffered PWM word (shadow written by SPI, active used by PWM)
//
// Purpose: holds one period or duty word. Writes land in the shadow copy;
//          the active copy follows only when apply (PWM wrap) pulses.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   load       in   write load_data into the shadow copy
//   load_data  in   DW-bit word to write
//   apply      in   period boundary: move a pending shadow word into active
//   shadow_q   out  last written value (readback source)
//   active_q   out  value currently driving the PWM

module pwm_shadow_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          apply,
  output logic [DW-1:0] shadow_q,
  output logic [DW-1:0] active_q
);

  logic pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pending  <= 1'b0;
    end else begin
      if (load) shadow_q <= load_data;
      if (apply) begin
        // A write landing on the wrap cycle goes straight through to active.
        if (load)         active_q <= load_data;
        else if (pending) active_q <= shadow_q;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_pwm_cmd_ctrl.sv
// rtl/spi_pwm_cmd_ctrl.sv - SPI byte-stream command sequencer owning the PWM configuration bank
//
// Purpose: parses {rw,addr} + burst {hi,lo} word frames from the SPI receiver,
//          writes CTRL/PERIOD/DUTY registers, supplies readback bytes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_strobe    1-cycle pulse, rx_byte valid
//   rx_byte      received SPI byte
//   cs_n_sync    synchronized chip select (active low), frames one command
//   pwm_wrap     1-cycle pulse at PWM period boundary
//   tx_byte      next byte for the SPI shifter
//   tx_load      1-cycle pulse, tx_byte updated
//   pwm_en       live channel enables
//   pwm_period   active period
//   pwm_duty     active duties, channel i at [i*DW +: DW]
//   frame_err    sticky bad-address flag, cleared by CTRL bit 15

module spi_pwm_cmd_ctrl
  import spi_pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DW     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_strobe,
  input  logic [7:0]           rx_byte,
  input  logic                 cs_n_sync,
  input  logic                 pwm_wrap,
  output logic [7:0]           tx_byte,
  output logic                 tx_load,
  output logic [NUM_CH-1:0]    pwm_en,
  output logic [DW-1:0]        pwm_period,
  output logic [NUM_CH*DW-1:0] pwm_duty,
  output logic                 frame_err
);

  state_t                  state;
  logic                    rw;
  logic [6:0]              addr;
  logic [6:0]              rd_addr;
  logic [7:0]              hi_byte;
  logic [DW-1:0]           wr_word;
  logic [DW-1:0]           rd_word;
  logic [NUM_CH:0][DW-1:0] sh_q;
  logic [NUM_CH:0][DW-1:0] act_q;
  logic [NUM_CH:0]         sh_load;
  logic                    commit;
  logic                    wr_period;
  logic                    wr_duty;

  // Word commit happens on the lo-byte strobe of a write frame, even if
  // chip select rises in that same cycle.
  assign wr_word   = {hi_byte, rx_byte};
  assign commit    = rx_strobe && (state == LO) && rw;
  assign wr_period = commit && (addr == ADDR_PERIOD);
  assign wr_duty   = commit && addr_is_duty(addr, NUM_CH);

  // Slot 0 is PERIOD, slot i+1 is DUTY[i].
  assign sh_load[0] = wr_period;

  pwm_shadow_reg #(.DW(DW)) u_period (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load[0]),
    .load_data (wr_word),
    .apply     (pwm_wrap),
    .shadow_q  (sh_q[0]),
    .active_q  (act_q[0])
  );

  assign pwm_period = act_q[0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_duty
    assign sh_load[i+1] = wr_duty && (addr[3:0] == 4'(i));

    pwm_shadow_reg #(.DW(DW)) u_duty (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sh_load[i+1]),
      .load_data (wr_word),
      .apply     (pwm_wrap),
      .shadow_q  (sh_q[i+1]),
      .active_q  (act_q[i+1])
    );

    assign pwm_duty[i*DW +: DW] = act_q[i+1];
  end

  // Address whose readback is needed by the state being entered: the new
  // address in CMD, the post-increment address in LO, else the current one.
  always_comb begin
    rd_addr = addr;
    if (state == CMD)     rd_addr = rx_byte[6:0];
    else if (state == LO) rd_addr = addr + 7'd1;
  end

  always_comb begin
    rd_word = '0;
    if (rd_addr == ADDR_CTRL) begin
      rd_word[NUM_CH-1:0] = pwm_en;
    end else if (rd_addr == ADDR_PERIOD) begin
      rd_word = sh_q[0];
    end else if (addr_is_duty(rd_addr, NUM_CH)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rd_addr[3:0] == 4'(i)) rd_word = sh_q[i+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rw        <= 1'b0;
      addr      <= '0;
      hi_byte   <= '0;
      tx_byte   <= '0;
      tx_load   <= 1'b0;
      pwm_en    <= '0;
      frame_err <= 1'b0;
    end else begin
      tx_load <= 1'b0;

      if (rx_strobe && state != IDLE) begin
        case (state)
          CMD: begin
            rw      <= rx_byte[7];
            addr    <= rx_byte[6:0];
            tx_byte <= rd_word[15:8];
            tx_load <= 1'b1;
            state   <= HI;
          end
          HI: begin
            if (rw) hi_byte <= rx_byte;
            tx_byte <= rd_word[7:0];
            tx_load <= 1'b1;
            state   <= LO;
          end
          LO: begin
            if (rw) begin
              if (addr == ADDR_CTRL) begin
                pwm_en <= wr_word[NUM_CH-1:0];
                if (wr_word[CTRL_CLR_ERR_BIT]) frame_err <= 1'b0;
              end else if (!(wr_period || wr_duty)) begin
                frame_err <= 1'b1;
              end
            end
            addr    <= addr + 7'd1;
            tx_byte <= rd_word[15:8];
            tx_load <= 1'b1;
            state   <= HI;
          end
          default: state <= IDLE;
        endcase
      end

      // Chip select overrides the byte-driven transition; a half-received
      // word held in hi_byte is simply never committed.
      if (cs_n_sync)          state <= IDLE;
      else if (state == IDLE) state <= CMD;
    end
  end

endmodule

// File: tb/tb_spi_pwm_cmd_ctrl.sv
// tb/tb_spi_pwm_cmd_ctrl.sv - self-checking bench for spi_pwm_cmd_ctrl against a register-map model

module tb_spi_pwm_cmd_ctrl;
  import spi_pwm_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rx_strobe = 1'b0;
  logic [7:0]           rx_byte = 8'h00;
  logic                 cs_n_sync = 1'b1;
  logic                 pwm_wrap = 1'b0;
  logic [7:0]           tx_byte;
  logic                 tx_load;
  logic [NUM_CH-1:0]    pwm_en;
  logic [DW-1:0]        pwm_period;
  logic [NUM_CH*DW-1:0] pwm_duty;
  logic                 frame_err;

  spi_pwm_cmd_ctrl #(.NUM_CH(NUM_CH), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_strobe  (rx_strobe),
    .rx_byte    (rx_byte),
    .cs_n_sync  (cs_n_sync),
    .pwm_wrap   (pwm_wrap),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .pwm_en     (pwm_en),
    .pwm_period (pwm_period),
    .pwm_duty   (pwm_duty),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register map as plain arrays. Index 0 = PERIOD, 1+i = DUTY[i].
  logic [15:0]       m_sh  [NUM_CH+1];
  logic [15:0]       m_act [NUM_CH+1];
  logic [NUM_CH-1:0] m_en;
  logic              m_err;
  logic [7:0]        frame_q[$];

  function automatic void m_reset();
    for (int i = 0; i <= NUM_CH; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_en  = '0;
    m_err = 1'b0;
  endfunction

  function automatic logic [15:0] m_read(input logic [6:0] a);
    if (a == 7'h00) return {{(16-NUM_CH){1'b0}}, m_en};
    if (a == 7'h01) return m_sh[0];
    if (int'(a) >= 16 && int'(a) < 16 + NUM_CH) return m_sh[int'(a) - 15];
    return 16'h0000;
  endfunction

  function automatic void m_write(input logic [6:0] a, input logic [15:0] w);
    if (a == 7'h00) begin
      m_en = w[NUM_CH-1:0];
      if (w[15]) m_err = 1'b0;
    end else if (a == 7'h01) begin
      m_sh[0] = w;
    end else if (int'(a) >= 16 && int'(a) < 16 + NUM_CH) begin
      m_sh[int'(a) - 15] = w;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  function automatic void m_wrap();
    for (int i = 0; i <= NUM_CH; i++) m_act[i] = m_sh[i];
  endfunction

  function automatic logic [NUM_CH*DW-1:0] m_duty();
    logic [NUM_CH*DW-1:0] d;
    for (int i = 0; i < NUM_CH; i++) d[i*DW +: DW] = m_act[i+1];
    return d;
  endfunction

  // One strobed byte, then a short window counting tx_load pulses.
  task automatic send_byte(input logic [7:0] b, input bit rise_cs, input bit wrap,
                           output int loads, output logic [7:0] txb);
    @(posedge clk); #1;
    rx_strobe = 1'b1;
    rx_byte   = b;
    if (rise_cs) cs_n_sync = 1'b1;
    if (wrap)    pwm_wrap  = 1'b1;
    @(posedge clk); #1;
    rx_strobe = 1'b0;
    pwm_wrap  = 1'b0;
    loads = 0;
    txb   = 8'h00;
    repeat (4) begin
      @(negedge clk);
      if (tx_load === 1'b1) begin
        loads++;
        txb = tx_byte;
      end
    end
  endtask

  // Full CS-low frame: cmd byte then frame_q data bytes. Read frames check tx.
  task automatic do_frame(input logic [7:0] cmd, input bit rise_last, input bit wrap_last);
    logic [6:0]  a;
    logic        rw;
    logic [7:0]  hi, b, exp_tx, txb;
    logic [15:0] w;
    int          loads, n;
    bit          last;
    n  = frame_q.size();
    a  = cmd[6:0];
    rw = cmd[7];
    hi = 8'h00;
    @(posedge clk); #1;
    cs_n_sync = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k <= n; k++) begin
      last = (k == n);
      if (k == 0) begin
        b = cmd;
        w = m_read(a);
        exp_tx = w[15:8];
      end else if (k % 2 == 1) begin
        b  = frame_q[k-1];
        hi = b;
        w  = m_read(a);
        exp_tx = w[7:0];
      end else begin
        b = frame_q[k-1];
        if (rw) m_write(a, {hi, b});
        a = a + 7'd1;
        w = m_read(a);
        exp_tx = w[15:8];
      end
      if (wrap_last && last) m_wrap();
      send_byte(b, rise_last && last, wrap_last && last, loads, txb);
      if (!rw) begin
        n_checks++;
        if (loads != 1) begin
          n_fail++;
          $display("FAIL tx_load_pulses byte%0d: got %0d expected 1", k, loads);
        end
        n_checks++;
        if (txb !== exp_tx) begin
          n_fail++;
          $display("FAIL tx_byte byte%0d: got %h expected %h", k, txb, exp_tx);
        end
      end
    end
    if (!rise_last) begin
      @(posedge clk); #1;
      cs_n_sync = 1'b1;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_wrap();
    @(posedge clk); #1;
    pwm_wrap = 1'b1;
    m_wrap();
    @(posedge clk); #1;
    pwm_wrap = 1'b0;
  endtask

  task automatic test_reset();
    m_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pwm_en !== '0 || pwm_period !== '0 || pwm_duty !== '0) begin
      n_fail++;
      $display("FAIL reset_pwm: got en=%h per=%h duty=%h expected all 0", pwm_en, pwm_period, pwm_duty);
    end
    n_checks++;
    if (frame_err !== 1'b0 || tx_load !== 1'b0 || tx_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_misc: got err=%b load=%b tx=%h expected 0", frame_err, tx_load, tx_byte);
    end
  endtask

  task automatic test_write_wrap();
    frame_q = {8'h03, 8'hE8};
    do_frame(8'h81, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (pwm_period !== m_act[0]) begin
      n_fail++;
      $display("FAIL period_before_wrap: got %0d expected %0d", pwm_period, m_act[0]);
    end
    do_wrap();
    @(negedge clk);
    n_checks++;
    if (pwm_period !== 16'd1000 || pwm_period !== m_act[0]) begin
      n_fail++;
      $display("FAIL period_after_wrap: got %0d expected 1000", pwm_period);
    end
  endtask

  task automatic test_read();
    frame_q = {8'h00, 8'h00};
    do_frame(8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_burst();
    frame_q = {8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
    do_frame(8'h90, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (pwm_duty !== m_duty()) begin
      n_fail++;
      $display("FAIL duty_before_wrap: got %h expected %h", pwm_duty, m_duty());
    end
    do_wrap();
    @(negedge clk);
    n_checks++;
    if (pwm_duty !== m_duty() || pwm_duty !== 64'h0004_0003_0002_0001) begin
      n_fail++;
      $display("FAIL burst_duty: got %h expected %h", pwm_duty, m_duty());
    end
  endtask

  task automatic test_abort();
    frame_q = {8'h12};
    do_frame(8'h81, 1'b0, 1'b0);
    do_wrap();
    @(negedge clk);
    n_checks++;
    if (pwm_period !== m_act[0]) begin
      n_fail++;
      $display("FAIL abort_period: got %0d expected %0d", pwm_period, m_act[0]);
    end
    n_checks++;
    if (dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL abort_state: got %0d expected %0d", dut.state, IDLE);
    end
  endtask

  task automatic test_idle_strobe();
    int         loads;
    logic [7:0] txb;
    send_byte(8'h81, 1'b0, 1'b0, loads, txb);
    send_byte(8'h55, 1'b0, 1'b0, loads, txb);
    send_byte(8'h66, 1'b0, 1'b0, loads, txb);
    do_wrap();
    @(negedge clk);
    n_checks++;
    if (pwm_period !== m_act[0] || loads != 0) begin
      n_fail++;
      $display("FAIL idle_strobe: got per=%0d loads=%0d expected per=%0d loads=0", pwm_period, loads, m_act[0]);
    end
  endtask

  task automatic test_bad_addr();
    frame_q = {8'h12, 8'h34};
    do_frame(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (frame_err !== m_err || frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_addr_err: got %b expected 1", frame_err);
    end
    frame_q = {8'h00, 8'h00};
    do_frame(8'h05, 1'b0, 1'b0);
    frame_q = {8'h80, 8'h05};
    do_frame(8'h80, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (frame_err !== 1'b0 || pwm_en !== 4'b0101 || pwm_en !== m_en) begin
      n_fail++;
      $display("FAIL ctrl_clear: got err=%b en=%b expected err=0 en=0101", frame_err, pwm_en);
    end
  endtask

  task automatic test_edge_timing();
    frame_q = {8'h07, 8'hD0};
    do_frame(8'h81, 1'b1, 1'b0);
    do_wrap();
    @(negedge clk);
    n_checks++;
    if (pwm_period !== 16'd2000 || pwm_period !== m_act[0]) begin
      n_fail++;
      $display("FAIL cs_rise_with_strobe: got %0d expected 2000", pwm_period);
    end
    frame_q = {8'h00, 8'h55};
    do_frame(8'h91, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (pwm_duty !== m_duty() || pwm_duty[31:16] !== 16'h0055) begin
      n_fail++;
      $display("FAIL commit_with_wrap: got %h expected %h", pwm_duty, m_duty());
    end
  endtask

  task automatic test_reset_mid_frame();
    int         loads;
    logic [7:0] txb;
    @(posedge clk); #1;
    cs_n_sync = 1'b0;
    repeat (2) @(posedge clk);
    send_byte(8'h81, 1'b0, 1'b0, loads, txb);
    send_byte(8'h22, 1'b0, 1'b0, loads, txb);
    @(posedge clk); #1;
    rx_strobe = 1'b1;
    rx_byte   = 8'h33;
    rst_n     = 1'b0;
    m_reset();
    @(posedge clk); #1;
    rx_strobe = 1'b0;
    cs_n_sync = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pwm_en !== '0 || pwm_period !== '0 || pwm_duty !== '0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_frame_reset: got en=%h per=%h duty=%h err=%b expected 0", pwm_en, pwm_period, pwm_duty, frame_err);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    do_wrap();
    @(negedge clk);
    n_checks++;
    if (pwm_period !== m_act[0]) begin
      n_fail++;
      $display("FAIL mid_frame_no_commit: got %0d expected %0d", pwm_period, m_act[0]);
    end
  endtask

  task automatic test_random();
    logic [6:0] a;
    bit         rw;
    int         nw;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0:       a = 7'h00;
        1:       a = 7'h01;
        2:       a = 7'($urandom_range(32, 127));
        default: a = 7'h10 + 7'($urandom_range(0, NUM_CH - 1));
      endcase
      rw = ($urandom_range(0, 1) == 1);
      nw = $urandom_range(1, 3);
      frame_q = {};
      for (int k = 0; k < 2 * nw; k++) frame_q.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0) void'(frame_q.pop_back());
      if ($urandom_range(0, 2) == 0) do_wrap();
      do_frame({rw, a}, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      @(negedge clk);
      n_checks++;
      if (pwm_en !== m_en || frame_err !== m_err) begin
        n_fail++;
        $display("FAIL rand%0d_ctrl: got en=%h err=%b expected en=%h err=%b", it, pwm_en, frame_err, m_en, m_err);
      end
      n_checks++;
      if (pwm_period !== m_act[0] || pwm_duty !== m_duty()) begin
        n_fail++;
        $display("FAIL rand%0d_pwm: got per=%h duty=%h expected per=%h duty=%h", it, pwm_period, pwm_duty, m_act[0], m_duty());
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_wrap();
    test_read();
    test_burst();
    test_abort();
    test_idle_strobe();
    test_bad_addr();
    test_edge_timing();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
